data_stack: RTL and testbench
=============================

DATA_STACK -- requirements
Module: data_stack

Interface
REQ-001 The block SHALL have parameter WIDTH, 16, data word width in bits.
REQ-002 The block SHALL have parameter DEPTH, 16, entry count; must be a power of two and at least 2.
REQ-003 The block SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port rst_stack  input  1  synchronous clear, issued by the control FSM.
REQ-006 The block SHALL have port push_stack  input  1  push din this cycle.
REQ-007 The block SHALL have port pop_stack  input  1  pop the top-of-stack (TOS) this cycle.
REQ-008 The block SHALL have port din  input  WIDTH  word to push.
REQ-009 The block SHALL have port tos  output  WIDTH  current TOS, combinational from storage; 0 when empty.
REQ-010 The block SHALL have port dout  output  WIDTH  registered copy of the last popped word.
REQ-011 The block SHALL have port count  output  $clog2(DEPTH)+1  number of valid entries.
REQ-012 The block SHALL have ports empty and full  output  1 each  count==0 and count==DEPTH respectively.
REQ-013 The block SHALL have ports overflow and underflow  output  1 each  sticky error flags.

Function
REQ-014 Storage SHALL be a DEPTH x WIDTH array addressed by a stack pointer sp; sp equals count.
REQ-015 Push only, not full: the block SHALL write din to entry sp and set sp to sp+1; tos SHALL show din the next cycle.
REQ-016 Pop only, not empty: the block SHALL set sp to sp-1 and set dout to the old TOS; dout SHALL be valid the cycle after pop_stack, which is the FSM's save cycle.
REQ-017 Push and pop together, not empty: the block SHALL replace the TOS. dout gets the old TOS, entry sp-1 gets din, and count is unchanged.
REQ-018 Push and pop together on an empty stack: the block SHALL treat it as a push only, set underflow, and leave dout unchanged.
REQ-019 Push only while full: the block SHALL ignore the push, keep the array and sp unchanged, and set overflow.
REQ-020 Pop only while empty: the block SHALL keep sp unchanged, keep dout unchanged, and set underflow.
REQ-021 dout SHALL hold its value in every cycle with no successful pop.
REQ-022 overflow and underflow SHALL stay set until rst or rst_stack.
REQ-023 rst_stack SHALL take priority over push and pop in the same cycle. It sets sp, dout, overflow and underflow to 0; array contents need not be cleared.
REQ-024 There SHALL be no wrap-around: sp never exceeds DEPTH and never goes below 0.
REQ-025 Control state SHALL be IDLE/OP decode only, with no multi-cycle states; every operation SHALL complete in one cycle.

Reset
REQ-026 On rst assertion, without waiting for a clock edge, the block SHALL set sp=0, dout=0, overflow=0 and underflow=0; consequently count=0, empty=1, full=0 and tos=0.
REQ-027 The array SHALL have no reset; reads of invalid entries SHALL never reach tos or dout.
REQ-028 rst asserted in the middle of a push or pop sequence SHALL discard that operation.

Structure
REQ-029 WIDTH and DEPTH defaults SHALL live in a shared package (stack_pkg) together with the instruction and state encodings used by the control FSM.
REQ-030 Storage SHALL be a sub-module stack_ram: one synchronous write port and one asynchronous read port, no reset. All pointer and flag logic SHALL stay in data_stack.

Verification
REQ-031 The bench SHALL run this scenario: reset, then push 0x0001, 0x0002, 0x0003 -> count=3, tos=0x0003, empty=0.
REQ-032 The bench SHALL run this scenario: from that state, pop twice -> dout=0x0003 and then 0x0002 on the following cycles, count=1, tos=0x0001.
REQ-033 The bench SHALL run this scenario: push 16 words 0x0100 to 0x010F, then push 0xBEEF -> full=1, overflow=1, tos=0x010F, count=16.
REQ-034 The bench SHALL run this scenario: pop on an empty stack -> underflow=1, count=0, dout unchanged; a later rst_stack -> underflow=0.
REQ-035 The bench SHALL run this scenario: tos=0x0005 with count=2, then push 0x0009 and pop in the same cycle -> dout=0x0005, tos=0x0009, count=2.
REQ-036 The bench SHALL run this scenario: assert rst between push cycles and at a different phase from the clock edge -> count=0, dout=0 and flags=0 immediately, and the interrupted push is lost.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared defaults and encodings for the data stack and its control FSM.
package stack_pkg;

  parameter int unsigned StackWidth = 16;
  parameter int unsigned StackDepth = 16;

  // Instruction encoding seen by the control FSM.
  typedef enum logic [1:0] {
    InstrNop,
    InstrPush,
    InstrPop,
    InstrSwap
  } stack_instr_e;

  // Control FSM states: decode only, every operation is single-cycle.
  typedef enum logic {
    StIdle,
    StOp
  } ctrl_state_e;

  // Per-cycle stack operation after resolving priority and boundary cases.
  typedef enum logic [2:0] {
    OpNone,
    OpClear,
    OpPush,
    OpPop,
    OpReplace,
    OpPushUnder,
    OpOverflow,
    OpUnderflow
  } stack_op_e;

  // Push+pop on an empty stack degrades to a push that also flags underflow.
  function automatic stack_op_e decode_op(logic clr, logic push, logic pop,
                                          logic is_empty, logic is_full);
    stack_op_e op;
    op = OpNone;
    if (clr) begin
      op = OpClear;
    end else if (push && pop) begin
      op = is_empty ? OpPushUnder : OpReplace;
    end else if (push) begin
      op = is_full ? OpOverflow : OpPush;
    end else if (pop) begin
      op = is_empty ? OpUnderflow : OpPop;
    end
    return op;
  endfunction

endpackage

// File: rtl/stack_ram.sv
// Stack storage: one synchronous write port, one asynchronous read port, no reset.
module stack_ram #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/data_stack.sv
// Hardware LIFO: pointer, output and sticky-flag logic around stack_ram.
module data_stack
  import stack_pkg::*;
#(
  parameter int unsigned WIDTH = StackWidth,
  parameter int unsigned DEPTH = StackDepth
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rst_stack,
  input  logic                    push_stack,
  input  logic                    pop_stack,
  input  logic [WIDTH-1:0]        din,
  output logic [WIDTH-1:0]        tos,
  output logic [WIDTH-1:0]        dout,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    empty,
  output logic                    full,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [CW-1:0]    r_sp, w_sp_nxt;
  logic [WIDTH-1:0] r_dout, w_dout_nxt;
  logic             r_of, w_of_nxt;
  logic             r_uf, w_uf_nxt;

  logic             w_empty, w_full;
  logic [AW-1:0]    w_sp_addr, w_top_addr, w_waddr;
  logic             w_we;
  logic [WIDTH-1:0] w_rdata, w_tos;
  stack_op_e        w_op;

  assign w_empty    = (r_sp == '0);
  assign w_full     = (r_sp == CW'(DEPTH));
  assign w_sp_addr  = AW'(r_sp);
  assign w_top_addr = AW'(r_sp - CW'(1));
  // Never expose a stale array word when the stack holds nothing.
  assign w_tos      = w_empty ? '0 : w_rdata;
  assign w_op       = decode_op(rst_stack, push_stack, pop_stack, w_empty, w_full);

  always_comb begin
    w_sp_nxt   = r_sp;
    w_dout_nxt = r_dout;
    w_of_nxt   = r_of;
    w_uf_nxt   = r_uf;
    w_we       = 1'b0;
    w_waddr    = w_sp_addr;
    unique case (w_op)
      OpClear: begin
        w_sp_nxt   = '0;
        w_dout_nxt = '0;
        w_of_nxt   = 1'b0;
        w_uf_nxt   = 1'b0;
      end
      OpPush: begin
        w_we     = 1'b1;
        w_sp_nxt = r_sp + CW'(1);
      end
      OpPushUnder: begin
        w_we     = 1'b1;
        w_sp_nxt = r_sp + CW'(1);
        w_uf_nxt = 1'b1;
      end
      OpPop: begin
        w_sp_nxt   = r_sp - CW'(1);
        w_dout_nxt = w_tos;
      end
      OpReplace: begin
        w_we       = 1'b1;
        w_waddr    = w_top_addr;
        w_dout_nxt = w_tos;
      end
      OpOverflow:  w_of_nxt = 1'b1;
      OpUnderflow: w_uf_nxt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sp   <= '0;
      r_dout <= '0;
      r_of   <= 1'b0;
      r_uf   <= 1'b0;
    end else begin
      r_sp   <= w_sp_nxt;
      r_dout <= w_dout_nxt;
      r_of   <= w_of_nxt;
      r_uf   <= w_uf_nxt;
    end
  end

  stack_ram #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_ram (
    .i_clk  (clk),
    .i_we   (w_we),
    .i_waddr(w_waddr),
    .i_wdata(din),
    .i_raddr(w_top_addr),
    .o_rdata(w_rdata)
  );

  assign tos       = w_tos;
  assign dout      = r_dout;
  assign count     = r_sp;
  assign empty     = w_empty;
  assign full      = w_full;
  assign overflow  = r_of;
  assign underflow = r_uf;

endmodule

// File: tb/tb_data_stack.sv
// Self-checking bench for data_stack: directed vector table, reset sequences, random vs. queue model.
module tb_data_stack;

  logic        clk = 1'b0;
  logic        rst;
  logic        rst_stack, push_stack, pop_stack;
  logic [15:0] din;
  logic [15:0] tos, dout;
  logic [4:0]  count;
  logic        empty, full, overflow, underflow;

  int n_checks = 0;
  int n_errors = 0;

  data_stack #(
    .WIDTH(16),
    .DEPTH(16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rst_stack (rst_stack),
    .push_stack(push_stack),
    .pop_stack (pop_stack),
    .din       (din),
    .tos       (tos),
    .dout      (dout),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ps, po, rs;
    logic [15:0] d;
    int          cnt;
    logic [15:0] tos, dout;
    logic        of, uf;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input int cnt, input logic [15:0] t,
                           input logic [15:0] d, input logic of, input logic uf);
    check({tag, ".count"}, 32'(count), 32'(cnt));
    check({tag, ".tos"}, 32'(tos), 32'(t));
    check({tag, ".dout"}, 32'(dout), 32'(d));
    check({tag, ".overflow"}, 32'(overflow), 32'(of));
    check({tag, ".underflow"}, 32'(underflow), 32'(uf));
    check({tag, ".empty"}, 32'(empty), 32'(cnt == 0));
    check({tag, ".full"}, 32'(full), 32'(cnt == 16));
  endtask

  task automatic add(input logic ps, input logic po, input logic rs, input logic [15:0] d,
                     input int cnt, input logic [15:0] t, input logic [15:0] o,
                     input logic of, input logic uf);
    vec_t v;
    v.ps = ps; v.po = po; v.rs = rs; v.d = d;
    v.cnt = cnt; v.tos = t; v.dout = o; v.of = of; v.uf = uf;
    vecs.push_back(v);
  endtask

  // Drive one cycle of controls, sample 1 time unit after the edge.
  task automatic apply(input logic ps, input logic po, input logic rs, input logic [15:0] d);
    push_stack = ps; pop_stack = po; rst_stack = rs; din = d;
    @(posedge clk);
    #1;
    push_stack = 1'b0; pop_stack = 1'b0; rst_stack = 1'b0;
  endtask

  // Reference model state
  logic [15:0] m_q[$];
  logic [15:0] m_dout;
  logic        m_of, m_uf;

  task automatic model_step(input logic ps, input logic po, input logic rs, input logic [15:0] d);
    if (rs) begin
      m_q.delete(); m_dout = '0; m_of = 1'b0; m_uf = 1'b0;
    end else if (ps && po) begin
      if (m_q.size() == 0) begin
        m_q.push_back(d); m_uf = 1'b1;
      end else begin
        m_dout = m_q[$];
        m_q[m_q.size() - 1] = d;
      end
    end else if (ps) begin
      if (m_q.size() == 16) m_of = 1'b1;
      else m_q.push_back(d);
    end else if (po) begin
      if (m_q.size() == 0) m_uf = 1'b1;
      else m_dout = m_q.pop_back();
    end
  endtask

  initial begin
    rst = 1'b1; rst_stack = 1'b0; push_stack = 1'b0; pop_stack = 1'b0; din = '0;
    #2;
    check_all("reset", 0, 16'h0, 16'h0, 1'b0, 1'b0);
    #6 rst = 1'b0;

    // Directed table
    add(1, 0, 0, 16'h0001, 1, 16'h0001, 16'h0000, 0, 0);
    add(1, 0, 0, 16'h0002, 2, 16'h0002, 16'h0000, 0, 0);
    add(1, 0, 0, 16'h0003, 3, 16'h0003, 16'h0000, 0, 0);
    add(0, 1, 0, 16'h0000, 2, 16'h0002, 16'h0003, 0, 0);
    add(0, 1, 0, 16'h0000, 1, 16'h0001, 16'h0002, 0, 0);
    add(0, 1, 0, 16'h0000, 0, 16'h0000, 16'h0001, 0, 0);
    add(0, 1, 0, 16'h0000, 0, 16'h0000, 16'h0001, 0, 1);
    add(0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0001, 0, 1);
    add(1, 1, 1, 16'h0077, 0, 16'h0000, 16'h0000, 0, 0);
    add(1, 0, 0, 16'h0004, 1, 16'h0004, 16'h0000, 0, 0);
    add(1, 0, 0, 16'h0005, 2, 16'h0005, 16'h0000, 0, 0);
    add(1, 1, 0, 16'h0009, 2, 16'h0009, 16'h0005, 0, 0);
    add(0, 1, 0, 16'h0000, 1, 16'h0004, 16'h0009, 0, 0);
    add(0, 0, 1, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0);
    for (int i = 0; i < 16; i++) begin
      add(1, 0, 0, 16'h0100 + 16'(i), i + 1, 16'h0100 + 16'(i), 16'h0000, 0, 0);
    end
    add(1, 0, 0, 16'hBEEF, 16, 16'h010F, 16'h0000, 1, 0);
    add(1, 1, 0, 16'hCAFE, 16, 16'hCAFE, 16'h010F, 1, 0);
    add(0, 1, 0, 16'h0000, 15, 16'h010E, 16'hCAFE, 1, 0);
    add(0, 0, 1, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0);
    add(1, 0, 0, 16'h0033, 1, 16'h0033, 16'h0000, 0, 0);
    add(0, 1, 0, 16'h0000, 0, 16'h0000, 16'h0033, 0, 0);
    add(1, 1, 0, 16'h0044, 1, 16'h0044, 16'h0033, 0, 1);
    add(0, 0, 1, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].ps, vecs[i].po, vecs[i].rs, vecs[i].d);
      check_all($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].tos, vecs[i].dout,
                vecs[i].of, vecs[i].uf);
    end

    // Async reset just before the falling edge while a push is pending
    apply(1, 0, 0, 16'h0011);
    apply(0, 1, 0, 16'h0000);
    apply(0, 1, 0, 16'h0000);
    apply(1, 0, 0, 16'h0022);
    check_all("pre_rst1", 1, 16'h0022, 16'h0011, 1'b0, 1'b1);
    push_stack = 1'b1; din = 16'h0033;
    #3 rst = 1'b1;
    #1 check_all("rst1_async", 0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    @(posedge clk); #2;
    rst = 1'b0; push_stack = 1'b0;
    check_all("rst1_held", 0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    apply(1, 0, 0, 16'h0044);
    check_all("post_rst1", 1, 16'h0044, 16'h0000, 1'b0, 1'b0);

    // Async reset just after the falling edge, overflow set beforehand
    for (int i = 0; i < 16; i++) apply(1, 0, 0, 16'h0200 + 16'(i));
    apply(0, 1, 0, 16'h0000);
    apply(1, 0, 0, 16'h0300);
    apply(1, 0, 0, 16'h0301);
    check_all("pre_rst2", 16, 16'h0300, 16'h020E, 1'b1, 1'b0);
    apply(0, 1, 0, 16'h0000);
    push_stack = 1'b1; din = 16'h0055;
    @(negedge clk); #2 rst = 1'b1;
    #1 check_all("rst2_async", 0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    @(posedge clk); #3;
    rst = 1'b0; push_stack = 1'b0;
    check_all("rst2_held", 0, 16'h0000, 16'h0000, 1'b0, 1'b0);

    // Random traffic against the queue model; first push-heavy, then pop-heavy
    m_q.delete(); m_dout = '0; m_of = 1'b0; m_uf = 1'b0;
    for (int c = 0; c < 600; c++) begin
      logic ps, po, rs;
      logic [15:0] d;
      int bias;
      bias = ((c / 150) % 2 == 0) ? 70 : 30;
      ps = ($urandom_range(99) < bias);
      po = ($urandom_range(99) < (100 - bias));
      rs = ($urandom_range(99) < 2);
      d  = 16'($urandom);
      apply(ps, po, rs, d);
      model_step(ps, po, rs, d);
      check_all($sformatf("rand%0d", c), m_q.size(),
                (m_q.size() == 0) ? 16'h0000 : m_q[$], m_dout, m_of, m_uf);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
